// File: rtl/sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sprite_ctrl
// Description : Sprite controller between the CPU register bus and NSPR
//               sprite engines.
//               - Double-buffered sprite position and enable registers.
//                 CPU writes go to a shadow set. A commit request copies the
//                 shadow set into the active set, one sprite per cycle,
//                 starting at the next frame pulse, so sprites never tear
//                 mid-frame.
//               - Priority compositor. The lowest-index enabled sprite that
//                 is drawing wins. One cycle of latency.
//               - Optional sticky collision flag.
//
// Optional feature (compile-time macro):
//   SPR_COLLISION_EN : when defined, collision detection is built.
//                      When undefined, `collision` is tied low.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   frame         one-cycle start-of-frame pulse
//   wr_en         register write strobe
//   wr_addr       {sprite index, field}
//                 field: 0=x, 1=y, 2=ctrl, 3=reserved
//   wr_data       write data; ctrl uses bit 0 as the enable
//   wr_rdy        write accepted when high (low while copying)
//   commit_req    request a shadow->active commit at the next frame
//   commit_pend   commit accepted and not yet complete
//   sprx, spry    packed active positions; sprite i at [i*CORDW +: CORDW]
//   spr_drawing   per-engine drawing flags
//   spr_pix       packed per-engine colour indices
//   pix           resolved colour index (registered)
//   drawing       an enabled sprite is drawing (registered)
//   spr_id        index of the winning sprite (registered)
//   collision     sticky collision flag
//
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_ctrl #(
    parameter int CORDW     = 16,
    parameter int NSPR      = 4,
    parameter int SPR_DATAW = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame,
    input  logic                        wr_en,
    input  logic [$clog2(NSPR)+1:0]     wr_addr,
    input  logic [CORDW-1:0]            wr_data,
    output logic                        wr_rdy,
    input  logic                        commit_req,
    output logic                        commit_pend,
    output logic [NSPR*CORDW-1:0]       sprx,
    output logic [NSPR*CORDW-1:0]       spry,
    input  logic [NSPR-1:0]             spr_drawing,
    input  logic [NSPR*SPR_DATAW-1:0]   spr_pix,
    output logic [SPR_DATAW-1:0]        pix,
    output logic                        drawing,
    output logic [$clog2(NSPR)-1:0]     spr_id,
    output logic                        collision
);

    localparam int c_IDW = $clog2(NSPR);
    localparam int c_AW  = c_IDW + 2;
    localparam logic [c_IDW-1:0] c_LAST = c_IDW'(NSPR - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_COPY  = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_IDW-1:0]       r_cnt;
    logic                   w_copy;

    // Shadow (CPU-facing) register set
    logic [CORDW-1:0]       r_shx [NSPR];
    logic [CORDW-1:0]       r_shy [NSPR];
    logic [NSPR-1:0]        r_shen;

    // Active register set
    logic [NSPR*CORDW-1:0]  r_sprx;
    logic [NSPR*CORDW-1:0]  r_spry;
    logic [NSPR-1:0]        r_en;

    logic                   w_wr;
    logic [c_IDW-1:0]       w_wr_idx;
    logic [1:0]             w_wr_fld;

    logic [NSPR-1:0]        w_hit;
    logic                   w_win;
    logic [c_IDW-1:0]       w_win_id;
    logic [SPR_DATAW-1:0]   w_win_pix;
    logic [SPR_DATAW-1:0]   r_pix;
    logic                   r_drawing;
    logic [c_IDW-1:0]       r_spr_id;

    // ------------------------------------------------------------------
    // Commit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Commit FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // A request that coincides with a frame pulse skips ARMED.
                if (commit_req) begin
                    w_state_nxt = frame ? c_ST_COPY : c_ST_ARMED;
                end
            end
            c_ST_ARMED: begin
                if (frame) begin
                    w_state_nxt = c_ST_COPY;
                end
            end
            c_ST_COPY: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Commit FSM: outputs
    always_comb begin
        commit_pend = (r_state != c_ST_IDLE);
        wr_rdy      = (r_state != c_ST_COPY);
        w_copy      = (r_state == c_ST_COPY);
    end

    // Copy counter: walks sprite indices while copying, then returns to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_copy) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Shadow register writes (dropped while copying)
    // ------------------------------------------------------------------
    assign w_wr     = wr_en && wr_rdy;
    assign w_wr_idx = wr_addr[c_AW-1:2];
    assign w_wr_fld = wr_addr[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSPR; i++) begin
                r_shx[i] <= '0;
                r_shy[i] <= '0;
            end
            r_shen <= '0;
        end else if (w_wr && (int'(w_wr_idx) < NSPR)) begin
            case (w_wr_fld)
                2'd0:    r_shx[w_wr_idx]  <= wr_data;
                2'd1:    r_shy[w_wr_idx]  <= wr_data;
                2'd2:    r_shen[w_wr_idx] <= wr_data[0];
                default: ;  // reserved field: write discarded
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Active set: one sprite copied per COPY cycle.
    // Reset clears it, so an interrupted copy leaves nothing behind.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sprx <= '0;
            r_spry <= '0;
            r_en   <= '0;
        end else if (w_copy) begin
            r_sprx[r_cnt*CORDW +: CORDW] <= r_shx[r_cnt];
            r_spry[r_cnt*CORDW +: CORDW] <= r_shy[r_cnt];
            r_en[r_cnt]                  <= r_shen[r_cnt];
        end
    end

    assign sprx = r_sprx;
    assign spry = r_spry;

    // ------------------------------------------------------------------
    // Compositor. Scanning from the top index down lets the lowest
    // drawing index overwrite any higher one, so it wins.
    // ------------------------------------------------------------------
    assign w_hit = spr_drawing & r_en;

    always_comb begin
        w_win     = 1'b0;
        w_win_id  = '0;
        w_win_pix = '0;
        for (int i = NSPR - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_win     = 1'b1;
                w_win_id  = c_IDW'(i);
                w_win_pix = spr_pix[i*SPR_DATAW +: SPR_DATAW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix     <= '0;
            r_drawing <= 1'b0;
            r_spr_id  <= '0;
        end else begin
            r_pix     <= w_win_pix;
            r_drawing <= w_win;
            r_spr_id  <= w_win_id;
        end
    end

    assign pix     = r_pix;
    assign drawing = r_drawing;
    assign spr_id  = r_spr_id;

    // ------------------------------------------------------------------
    // Collision detection (optional)
    // ------------------------------------------------------------------
`ifdef SPR_COLLISION_EN
    logic w_multi;
    logic w_seen;
    logic w_enter_copy;
    logic r_collision;

    // Two or more enabled sprites drawing in the same cycle.
    always_comb begin
        w_multi = 1'b0;
        w_seen  = 1'b0;
        for (int i = 0; i < NSPR; i++) begin
            if (w_hit[i]) begin
                if (w_seen) begin
                    w_multi = 1'b1;
                end
                w_seen = 1'b1;
            end
        end
    end

    assign w_enter_copy = (w_state_nxt == c_ST_COPY) && (r_state != c_ST_COPY);

    // Cleared on entry to COPY; a collision in that same cycle still sets it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_collision <= 1'b0;
        end else if (w_enter_copy) begin
            r_collision <= w_multi;
        end else if (w_multi) begin
            r_collision <= 1'b1;
        end
    end

    assign collision = r_collision;
`else
    assign collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_ctrl
// Description : Directed self-checking bench for sprite_ctrl
//               (NSPR=4, CORDW=16, SPR_DATAW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_ctrl;

    localparam int CORDW     = 16;
    localparam int NSPR      = 4;
    localparam int SPR_DATAW = 4;

`ifdef SPR_COLLISION_EN
    localparam logic c_COL = 1'b1;
`else
    localparam logic c_COL = 1'b0;
`endif

    logic                       clk;
    logic                       rst;
    logic                       frame;
    logic                       wr_en;
    logic [3:0]                 wr_addr;
    logic [CORDW-1:0]           wr_data;
    logic                       wr_rdy;
    logic                       commit_req;
    logic                       commit_pend;
    logic [NSPR*CORDW-1:0]      sprx;
    logic [NSPR*CORDW-1:0]      spry;
    logic [NSPR-1:0]            spr_drawing;
    logic [NSPR*SPR_DATAW-1:0]  spr_pix;
    logic [SPR_DATAW-1:0]       pix;
    logic                       drawing;
    logic [1:0]                 spr_id;
    logic                       collision;

    int errors = 0;
    int checks = 0;

    sprite_ctrl #(
        .CORDW     (CORDW),
        .NSPR      (NSPR),
        .SPR_DATAW (SPR_DATAW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame       (frame),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_rdy      (wr_rdy),
        .commit_req  (commit_req),
        .commit_pend (commit_pend),
        .sprx        (sprx),
        .spry        (spry),
        .spr_drawing (spr_drawing),
        .spr_pix     (spr_pix),
        .pix         (pix),
        .drawing     (drawing),
        .spr_id      (spr_id),
        .collision   (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int idx, input int fld, input int data);
        wr_en   = 1'b1;
        wr_addr = 4'((idx << 2) | fld);
        wr_data = CORDW'(data);
        tick();
        wr_en   = 1'b0;
    endtask

    // Commit with the frame pulse in the same cycle, then let the copy finish.
    task automatic commit_now();
        commit_req = 1'b1;
        frame      = 1'b1;
        tick();
        commit_req = 1'b0;
        frame      = 1'b0;
        repeat (NSPR) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++; if (sprx !== '0) begin errors++; $display("FAIL reset_sprx: got %h expected 0", sprx); end
        checks++; if (spry !== '0) begin errors++; $display("FAIL reset_spry: got %h expected 0", spry); end
        checks++; if (wr_rdy !== 1'b1) begin errors++; $display("FAIL reset_wr_rdy: got %b expected 1", wr_rdy); end
        checks++; if (commit_pend !== 1'b0) begin errors++; $display("FAIL reset_commit_pend: got %b expected 0", commit_pend); end
        checks++; if ({pix, drawing, spr_id, collision} !== '0) begin errors++;
            $display("FAIL reset_comp: got pix=%0d drawing=%b id=%0d col=%b expected all 0", pix, drawing, spr_id, collision); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_commit();
        write_reg(2, 0, 100);
        write_reg(2, 1, 50);
        write_reg(2, 2, 1);
        write_reg(2, 3, 16'hFFFF);  // reserved field, must be discarded
        checks++; if (sprx[2*CORDW +: CORDW] !== 16'd0) begin errors++; $display("FAIL commit_pre_sprx2: got %0d expected 0", sprx[2*CORDW +: CORDW]); end
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        checks++; if (commit_pend !== 1'b1) begin errors++; $display("FAIL commit_armed_pend: got %b expected 1", commit_pend); end
        repeat (9) tick();
        checks++; if ({sprx[2*CORDW +: CORDW], wr_rdy} !== {16'd0, 1'b1}) begin errors++;
            $display("FAIL commit_armed_hold: got x=%0d rdy=%b expected x=0 rdy=1", sprx[2*CORDW +: CORDW], wr_rdy); end
        frame = 1'b1;
        tick();                     // edge N
        frame = 1'b0;
        checks++; if (wr_rdy !== 1'b0) begin errors++; $display("FAIL commit_copy_rdy: got %b expected 0", wr_rdy); end
        tick();                     // N+1
        tick();                     // N+2
        checks++; if (sprx[2*CORDW +: CORDW] !== 16'd0) begin errors++; $display("FAIL commit_early_sprx2: got %0d expected 0", sprx[2*CORDW +: CORDW]); end
        tick();                     // N+3
        checks++; if (sprx[2*CORDW +: CORDW] !== 16'd100) begin errors++; $display("FAIL commit_sprx2: got %0d expected 100", sprx[2*CORDW +: CORDW]); end
        checks++; if (spry[2*CORDW +: CORDW] !== 16'd50) begin errors++; $display("FAIL commit_spry2: got %0d expected 50", spry[2*CORDW +: CORDW]); end
        checks++; if (commit_pend !== 1'b1) begin errors++; $display("FAIL commit_pend_n3: got %b expected 1", commit_pend); end
        tick();                     // N+4
        checks++; if ({commit_pend, wr_rdy} !== 2'b01) begin errors++;
            $display("FAIL commit_done: got pend=%b rdy=%b expected pend=0 rdy=1", commit_pend, wr_rdy); end
    endtask

    task automatic test_same_cycle_write_drop();
        commit_req = 1'b1;
        frame      = 1'b1;
        tick();                     // edge M: straight into COPY
        commit_req = 1'b0;
        frame      = 1'b0;
        checks++; if ({commit_pend, wr_rdy} !== 2'b10) begin errors++;
            $display("FAIL samecyc_copy: got pend=%b rdy=%b expected pend=1 rdy=0", commit_pend, wr_rdy); end
        write_reg(2, 0, 777);       // M+1, must be dropped
        repeat (3) tick();          // M+4
        checks++; if (sprx[2*CORDW +: CORDW] !== 16'd100) begin errors++; $display("FAIL drop_sprx2: got %0d expected 100", sprx[2*CORDW +: CORDW]); end
        checks++; if (commit_pend !== 1'b0) begin errors++; $display("FAIL samecyc_done: got %b expected 0", commit_pend); end
    endtask

    task automatic test_compositor();
        write_reg(1, 2, 1);
        write_reg(3, 2, 1);
        write_reg(2, 2, 0);
        commit_now();
        spr_drawing = 4'b1010;
        spr_pix     = {4'd9, 4'd0, 4'd5, 4'd0};
        tick();
        checks++; if ({pix, spr_id, drawing} !== {4'd5, 2'd1, 1'b1}) begin errors++;
            $display("FAIL comp_low_wins: got pix=%0d id=%0d drawing=%b expected pix=5 id=1 drawing=1", pix, spr_id, drawing); end
        // Disable sprite 1 while it keeps drawing; its enable copies at M+2.
        write_reg(1, 2, 0);
        commit_req = 1'b1;
        frame      = 1'b1;
        tick();                     // M
        commit_req = 1'b0;
        frame      = 1'b0;
        tick();                     // M+1
        tick();                     // M+2
        checks++; if ({pix, spr_id} !== {4'd5, 2'd1}) begin errors++;
            $display("FAIL comp_en_latency: got pix=%0d id=%0d expected pix=5 id=1", pix, spr_id); end
        tick();                     // M+3
        checks++; if ({pix, spr_id, drawing} !== {4'd9, 2'd3, 1'b1}) begin errors++;
            $display("FAIL comp_disable1: got pix=%0d id=%0d drawing=%b expected pix=9 id=3 drawing=1", pix, spr_id, drawing); end
        tick();                     // M+4, copy complete
    endtask

    task automatic test_disabled_sprite();
        spr_drawing = 4'b0001;
        spr_pix     = {4'd0, 4'd0, 4'd0, 4'd7};
        tick();
        checks++; if ({pix, drawing, spr_id} !== {4'd0, 1'b0, 2'd0}) begin errors++;
            $display("FAIL disabled_s0: got pix=%0d drawing=%b id=%0d expected 0 0 0", pix, drawing, spr_id); end
        spr_drawing = '0;
        tick();
    endtask

    task automatic test_collision();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        write_reg(0, 2, 1);
        write_reg(1, 2, 1);
        spr_pix = {4'd0, 4'd0, 4'd3, 4'd7};
        // Only sprite 0 drawing: no collision
        spr_drawing = 4'b0001;
        commit_now();
        tick();
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL col_single: got %b expected 0", collision); end
        spr_drawing = 4'b0011;
        tick();
        spr_drawing = 4'b0000;
        checks++; if ({pix, spr_id} !== {4'd7, 2'd0}) begin errors++;
            $display("FAIL col_pix: got pix=%0d id=%0d expected pix=7 id=0", pix, spr_id); end
        checks++; if (collision !== c_COL) begin errors++; $display("FAIL col_set: got %b expected %b", collision, c_COL); end
        repeat (3) tick();
        checks++; if (collision !== c_COL) begin errors++; $display("FAIL col_held: got %b expected %b", collision, c_COL); end
        commit_req = 1'b1;
        frame      = 1'b1;
        tick();                     // entering COPY clears it
        commit_req = 1'b0;
        frame      = 1'b0;
        checks++; if (collision !== 1'b0) begin errors++; $display("FAIL col_clear: got %b expected 0", collision); end
        repeat (NSPR) tick();
    endtask

    task automatic test_reset_mid_copy();
        write_reg(0, 0, 16'h1234);
        write_reg(0, 1, 16'h0042);
        spr_drawing = 4'b0001;
        spr_pix     = {4'd0, 4'd0, 4'd0, 4'd7};
        commit_req  = 1'b1;
        frame       = 1'b1;
        tick();                     // COPY entered
        commit_req  = 1'b0;
        frame       = 1'b0;
        tick();                     // sprite 0 copied
        checks++; if ({sprx[0 +: CORDW], pix} !== {16'h1234, 4'd7}) begin errors++;
            $display("FAIL midcopy_pre: got x=%h pix=%0d expected x=1234 pix=7", sprx[0 +: CORDW], pix); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if ({sprx, spry} !== '0) begin errors++; $display("FAIL midcopy_pos: got x=%h y=%h expected 0", sprx, spry); end
        checks++; if ({commit_pend, wr_rdy, pix, drawing, collision} !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin errors++;
            $display("FAIL midcopy_ctl: got pend=%b rdy=%b pix=%0d drawing=%b col=%b expected 0 1 0 0 0", commit_pend, wr_rdy, pix, drawing, collision); end
        tick();
        rst = 1'b0;
        // Shadow was cleared too: a fresh commit leaves sprite 0 at zero.
        commit_now();
        checks++; if ({sprx[0 +: CORDW], spry[0 +: CORDW], commit_pend} !== {32'd0, 1'b0}) begin errors++;
            $display("FAIL midcopy_shadow: got x=%h y=%h pend=%b expected 0 0 0", sprx[0 +: CORDW], spry[0 +: CORDW], commit_pend); end
    endtask

    initial begin
        rst         = 1'b1;
        frame       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        commit_req  = 1'b0;
        spr_drawing = '0;
        spr_pix     = '0;

        test_reset();
        test_commit();
        test_same_cycle_write_drop();
        test_compositor();
        test_disabled_sprite();
        test_collision();
        test_reset_mid_copy();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_ctrl.md
# sprite_ctrl

Sprite controller that sits between the CPU-side register bus and a bank of `NSPR` sprite engine instances. It holds double-buffered sprite position and enable registers: CPU writes land in a shadow set, and a commit request copies them into the active set at the next frame start, so sprites never tear mid-frame. It also arbitrates the per-pixel outputs of all engines into a single priority-resolved colour index, and optionally flags sprite-to-sprite collisions.

## Interface
- `CORDW`, 16, signed coordinate width (bits)
- `NSPR`, 4, number of sprite engines (2..16)
- `SPR_DATAW`, 4, bits per pixel colour index
- `clk`  in  1  clock
- `rst`  in  1  reset; **asynchronous, active-high**
- `frame`  in  1  one-cycle pulse at start of frame (vertical blank)
- `wr_en`  in  1  register write strobe
- `wr_addr`  in  $clog2(NSPR)+2  {sprite index, field}; field 0=x, 1=y, 2=ctrl, 3=reserved
- `wr_data`  in  CORDW  write data; ctrl uses bit 0 = enable
- `wr_rdy`  out  1  write accepted when high
- `commit_req`  in  1  one-cycle request to commit shadow to active at next `frame`
- `commit_pend`  out  1  high from accepted request until copy complete
- `sprx`, `spry`  out  NSPR*CORDW  packed active positions; sprite i at bits [i*CORDW +: CORDW]
- `spr_drawing`  in  NSPR  per-engine drawing flags
- `spr_pix`  in  NSPR*SPR_DATAW  packed per-engine colour indices
- `pix`  out  SPR_DATAW  resolved colour index
- `drawing`  out  1  any enabled sprite drawing
- `spr_id`  out  $clog2(NSPR)  index of winning sprite
- `collision`  out  1  sticky collision flag

## Operation
- Shadow set: x, y, en per sprite. Write with `wr_en && wr_rdy` updates the addressed field on next edge; field 3 writes discarded. Writes with `wr_rdy` low dropped.
- Active set: x, y, en per sprite; drives `sprx`/`spry` directly; en masks `spr_drawing`.
- State machine:
  - IDLE: `commit_req` → ARMED; if `frame` same cycle → COPY directly.
  - ARMED: `frame` → COPY. Further `commit_req` ignored.
  - COPY: counter i from 0; each cycle copies shadow sprite i (x, y, en) to active; after i=NSPR-1 → IDLE, counter to 0. `frame`/`commit_req` ignored.
- `commit_pend` = state != IDLE. `wr_rdy` = state != COPY.
- Compositor: lowest index among sprites with `spr_drawing[i] && en[i]` wins; register `pix`, `drawing=1`, `spr_id=i`. No winner: `pix=0`, `drawing=0`, `spr_id=0`.
- Reset: all shadow and active registers 0, en 0, state IDLE, counter 0; `pix`, `drawing`, `spr_id`, `collision`, `commit_pend` 0; `wr_rdy` 1. Reset mid-COPY aborts; partial copy lost (active cleared).

## Timing
- Write: visible in shadow one cycle after strobe edge.
- Commit: `frame` seen at edge N in ARMED → sprite i active registers update at edge N+1+i; `commit_pend` falls at edge N+NSPR; `wr_rdy` low for NSPR cycles.
- Compositor latency: exactly 1 cycle from `spr_drawing`/`spr_pix` to `pix`/`drawing`/`spr_id`; no stall.
- Active-set enable change takes effect on compositor in the cycle after its copy edge.

## Configuration
- `SPR_COLLISION_EN` defined: `collision` sets (registered, 1 cycle) when ≥2 enabled sprites draw in the same cycle; stays set until the cycle COPY is entered, which clears it (set in that same cycle wins).
- Undefined: no detection logic; `collision` tied 0.

## Test plan
- Reset: assert `rst` async mid-cycle → all outputs 0, `wr_rdy`=1, `sprx`/`spry`=0 immediately.
- Write sprite 2 x=100, y=50, en=1, `commit_req`, `frame` 10 cycles later → `sprx[2]`=100, `spry[2]`=50 at edge frame+3; `commit_pend` falls at frame+4 (NSPR=4); before frame, outputs unchanged.
- `commit_req` and `frame` same cycle in IDLE → COPY starts next cycle; write during COPY dropped (`wr_rdy`=0), shadow unchanged.
- Sprites 1 and 3 enabled, both drawing, pix 5 and 9 → next cycle `pix`=5, `spr_id`=1, `drawing`=1; sprite 1 disabled → `pix`=9, `spr_id`=3.
- Disabled sprite 0 drawing alone with pix 7 → `drawing`=0, `pix`=0.
- With `SPR_COLLISION_EN`: sprites 0 and 1 overlap one cycle → `collision`=1 and held; next commit entering COPY clears it; without macro → `collision` stays 0.
